branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Sits in the EX stage and closes the loop with the branch predictor.
- Carries each fetched instruction's prediction (take, destination) through IF→ID→EX alongside the pipeline, then compares it with the actual outcome in EX.
- Drives the predictor feedback bundle (feedback_valid, set_pc, set_taken, set_destination) and the fetch-redirect/flush request on a mispredict.
- Keeps saturating branch and mispredict counters for performance profiling.

Parameters:
- CHECK_TARGET, 1, when 1, a taken/taken pair with differing destinations counts as a mispredict (BTB build); when 0, only direction is checked.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-high (asserted = 1), sampled on clk rising edge
- if_valid_i  in  1  IF stage holds a valid fetched instruction
- if_pc_i  in  32  PC of the IF instruction
- pred_take_i  in  1  predictor take_branch for if_pc_i
- pred_dest_i  in  32  predictor predicted_destination for if_pc_i
- stall_i  in  1  pipeline hold; all tracking stages freeze
- flush_i  in  1  external flush of IF/ID (e.g. trap); EX unaffected
- ex_is_branch_i  in  1  EX instruction is a conditional branch or jump
- ex_taken_i  in  1  actual outcome in EX
- ex_target_i  in  32  actual target in EX
- feedback_valid  out  1  registered; one-cycle pulse per resolved branch
- set_pc  out  32  registered; PC of the resolved branch
- set_taken  out  1  registered; actual outcome
- set_destination  out  32  registered; actual target, bit 0 forced to 0
- mispredict_o  out  1  combinational; redirect fetch this cycle
- redirect_pc_o  out  32  combinational; correct next PC
- branch_cnt_o  out  CNT_W  resolved-branch count
- mispredict_cnt_o  out  CNT_W  mispredict count

Behaviour:
- Tracking pipe: two register slots, ID and EX, each holding {valid, pc, pred_take, pred_dest}.
- On each clk with stall_i=0: ID ← IF inputs; EX ← ID.
- stall_i=1: both slots hold their values; mispredict_o=0; nothing is resolved or counted.
- resolve = EX.valid & ex_is_branch_i & ~stall_i.
- Mispredict condition: resolve & ((EX.pred_take != ex_taken_i) | (CHECK_TARGET & ex_taken_i & EX.pred_take & (EX.pred_dest[31:1] != ex_target_i[31:1]))).
- redirect_pc_o = ex_taken_i ? {ex_target_i[31:1],1'b0} : EX.pc + 4 (32-bit wrap). It is valid only when mispredict_o=1; otherwise it is 0.
- On mispredict, next cycle: ID.valid=0 and EX.valid=0, because both hold wrong-path instructions. The IF input is also ignored that edge.
- flush_i=1 with stall_i=0: ID.valid=0 next cycle; EX still advances from the old ID contents.
- flush_i=1 with stall_i=1: ID.valid=0 next cycle; EX holds.
- Mispredict and flush_i in the same cycle: mispredict rule wins, so both slots are invalidated.
- Feedback register, 1-cycle latency: on the edge after resolve=1, feedback_valid=1 and set_pc=EX.pc, set_taken=ex_taken_i, set_destination={ex_target_i[31:1],0}. In all other cycles feedback_valid=0 and the data fields hold their last value.
- Counters:
  - branch_cnt_o increments on resolve.
  - mispredict_cnt_o increments on mispredict.
  - Both saturate at all-ones and never wrap.
- Reset (rst_n=1 at an edge), including mid-operation:
  - ID.valid=0, EX.valid=0.
  - feedback_valid=0, set_pc=0, set_taken=0, set_destination=0.
  - Both counters = 0.
  - Takes priority over stall_i and flush_i.
  - mispredict_o=0 and redirect_pc_o=0 from the first cycle after reset.
- A non-branch instruction in EX (ex_is_branch_i=0) yields no feedback, no count, and no redirect, even if its predicted take was 1.

Test Plan:
- Correct prediction: IF pc=0x100, pred_take=1, pred_dest=0x200; 2 cycles later EX reports taken=1, target=0x200 → mispredict_o=0; next cycle feedback_valid=1, set_pc=0x100, set_taken=1, set_destination=0x200; branch_cnt=1, mispredict_cnt=0.
- Direction mispredict: pc=0x40, pred_take=0; EX taken=1, target=0x80 → same cycle mispredict_o=1, redirect_pc_o=0x80; next cycle ID/EX valid=0, so a following branch in ID produces no feedback; mispredict_cnt=1.
- Not-taken fallthrough: pc=0xFFFFFFFC, pred_take=1; EX taken=0 → redirect_pc_o=0x00000000 (wrap).
- Target mispredict: CHECK_TARGET=1, pred 0x300, actual 0x304, both taken → mispredict_o=1, redirect 0x304. Same stimulus with CHECK_TARGET=0 → mispredict_o=0.
- Stall: hold stall_i=1 for 3 cycles with a branch in EX → no feedback pulse and counters unchanged; release → exactly one feedback pulse and branch_cnt +1.
- Reset mid-stream plus saturation: assert rst_n with a branch in EX → all outputs 0 next cycle and no later feedback. Separately, force mispredict_cnt to 2^CNT_W−1, then one more mispredict → value unchanged.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver: carries each fetched instruction's branch prediction from IF
// through ID and EX. It checks the prediction against the real outcome in EX,
// then drives predictor feedback and the fetch redirect, and counts branches
// and mispredicts for profiling.
module branch_resolver #(
  parameter bit CHECK_TARGET = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  input  logic [31:0]      if_pc_i,
  input  logic             pred_take_i,
  input  logic [31:0]      pred_dest_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_target_i,
  output logic             feedback_valid,
  output logic [31:0]      set_pc,
  output logic             set_taken,
  output logic [31:0]      set_destination,
  output logic             mispredict_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             id_vld_q, id_vld_d;
  logic [31:0]      id_pc_q, id_dest_q;
  logic             id_take_q;
  logic             ex_vld_q, ex_vld_d;
  logic [31:0]      ex_pc_q, ex_dest_q;
  logic             ex_take_q;

  logic             fb_vld_q;
  logic [31:0]      set_pc_q, set_dest_q;
  logic             set_taken_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic             resolve, dir_miss, tgt_miss, mispredict;
  logic [31:0]      actual_dest;

  // The target is always halfword aligned, so bit 0 of the reported target is ignored.
  assign actual_dest = {ex_target_i[31:1], 1'b0};
  assign resolve     = ex_vld_q & ex_is_branch_i & ~stall_i;
  assign dir_miss    = ex_take_q ^ ex_taken_i;
  assign tgt_miss    = CHECK_TARGET & ex_taken_i & ex_take_q &
                       (ex_dest_q[31:1] != ex_target_i[31:1]);
  assign mispredict  = resolve & (dir_miss | tgt_miss);

  assign mispredict_o  = mispredict;
  assign redirect_pc_o = !mispredict ? 32'd0 :
                         (ex_taken_i ? actual_dest : ex_pc_q + 32'd4);

  // Next-state valid bits: a mispredict kills both wrong-path slots, and a flush only kills ID.
  always_comb begin
    id_vld_d = id_vld_q;
    ex_vld_d = ex_vld_q;
    if (mispredict) begin
      id_vld_d = 1'b0;
      ex_vld_d = 1'b0;
    end else if (stall_i) begin
      if (flush_i) id_vld_d = 1'b0;
    end else begin
      id_vld_d = if_valid_i & ~flush_i;
      ex_vld_d = id_vld_q;
    end
  end

  // Saturating next-state values for the profiling counters.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && (br_cnt_q != '1))    br_cnt_d = br_cnt_q + CNT_ONE;
    if (mispredict && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_ONE;
  end

  // Slot valid bits, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      id_vld_q <= 1'b0;
      ex_vld_q <= 1'b0;
    end else begin
      id_vld_q <= id_vld_d;
      ex_vld_q <= ex_vld_d;
    end
  end

  // Slot payloads advance whenever the pipe moves. The valid bits decide if a payload is used.
  always_ff @(posedge clk) begin
    if (!stall_i) begin
      id_pc_q   <= if_pc_i;
      id_take_q <= pred_take_i;
      id_dest_q <= pred_dest_i;
      ex_pc_q   <= id_pc_q;
      ex_take_q <= id_take_q;
      ex_dest_q <= id_dest_q;
    end
  end

  // Predictor feedback: a one-cycle pulse per resolved branch. The data fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      fb_vld_q    <= 1'b0;
      set_pc_q    <= 32'd0;
      set_taken_q <= 1'b0;
      set_dest_q  <= 32'd0;
    end else begin
      fb_vld_q <= resolve;
      if (resolve) begin
        set_pc_q    <= ex_pc_q;
        set_taken_q <= ex_taken_i;
        set_dest_q  <= actual_dest;
      end
    end
  end

  // Performance counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign feedback_valid   = fb_vld_q;
  assign set_pc           = set_pc_q;
  assign set_taken        = set_taken_q;
  assign set_destination  = set_dest_q;
  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver. It drives a target-checking instance (32-bit
// counters) and a direction-only instance (3-bit counters) from the same inputs.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        pred_take_i = 1'b0;
  logic [31:0] pred_dest_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ex_is_branch_i = 1'b0;
  logic        ex_taken_i = 1'b0;
  logic [31:0] ex_target_i = '0;

  logic        d_fb, d_stk, d_mis;
  logic [31:0] d_spc, d_sdst, d_red, d_bc, d_mc;
  logic        n_fb, n_stk, n_mis;
  logic [31:0] n_spc, n_sdst, n_red;
  logic [2:0]  n_bc, n_mc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolver #(.CHECK_TARGET(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .pred_take_i(pred_take_i), .pred_dest_i(pred_dest_i), .stall_i(stall_i),
    .flush_i(flush_i), .ex_is_branch_i(ex_is_branch_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .feedback_valid(d_fb), .set_pc(d_spc),
    .set_taken(d_stk), .set_destination(d_sdst), .mispredict_o(d_mis),
    .redirect_pc_o(d_red), .branch_cnt_o(d_bc), .mispredict_cnt_o(d_mc));

  branch_resolver #(.CHECK_TARGET(1'b0), .CNT_W(3)) u_nt (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .pred_take_i(pred_take_i), .pred_dest_i(pred_dest_i), .stall_i(stall_i),
    .flush_i(flush_i), .ex_is_branch_i(ex_is_branch_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .feedback_valid(n_fb), .set_pc(n_spc),
    .set_taken(n_stk), .set_destination(n_sdst), .mispredict_o(n_mis),
    .redirect_pc_o(n_red), .branch_cnt_o(n_bc), .mispredict_cnt_o(n_mc));

  // Reference model: index 0 checks the target, index 1 checks only the direction.
  logic        m_id_v[2], m_id_take[2], m_ex_v[2], m_ex_take[2];
  logic [31:0] m_id_pc[2], m_id_dest[2], m_ex_pc[2], m_ex_dest[2];
  logic        m_fb[2], m_stk[2];
  logic [31:0] m_spc[2], m_sdst[2], m_bc[2], m_mc[2];
  logic [31:0] m_max[2] = '{32'hFFFF_FFFF, 32'd7};
  logic        e_res[2], e_mis[2];
  logic [31:0] e_red[2];

  task automatic model_comb();
    for (int k = 0; k < 2; k++) begin
      logic wrong_dir, wrong_tgt;
      e_res[k]  = m_ex_v[k] && ex_is_branch_i && !stall_i;
      wrong_dir = (m_ex_take[k] != ex_taken_i);
      wrong_tgt = (k == 0) && ex_taken_i && m_ex_take[k] &&
                  ((m_ex_dest[k] >> 1) != (ex_target_i >> 1));
      e_mis[k]  = e_res[k] && (wrong_dir || wrong_tgt);
      if (!e_mis[k])      e_red[k] = 32'd0;
      else if (ex_taken_i) e_red[k] = ex_target_i & 32'hFFFF_FFFE;
      else                e_red[k] = m_ex_pc[k] + 32'd4;
    end
  endtask

  task automatic tick();
    model_comb();
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        m_id_v[k] = 0; m_ex_v[k] = 0; m_fb[k] = 0; m_stk[k] = 0;
        m_spc[k] = 0; m_sdst[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
      end else begin
        m_fb[k] = e_res[k];
        if (e_res[k]) begin
          m_spc[k]  = m_ex_pc[k];
          m_stk[k]  = ex_taken_i;
          m_sdst[k] = ex_target_i & 32'hFFFF_FFFE;
          if (m_bc[k] != m_max[k]) m_bc[k] = m_bc[k] + 1;
        end
        if (e_mis[k] && m_mc[k] != m_max[k]) m_mc[k] = m_mc[k] + 1;
        if (e_mis[k]) begin
          m_id_v[k] = 0; m_ex_v[k] = 0;
        end else if (stall_i) begin
          if (flush_i) m_id_v[k] = 0;
        end else begin
          m_ex_v[k] = m_id_v[k]; m_ex_pc[k] = m_id_pc[k];
          m_ex_take[k] = m_id_take[k]; m_ex_dest[k] = m_id_dest[k];
          m_id_v[k] = if_valid_i && !flush_i; m_id_pc[k] = if_pc_i;
          m_id_take[k] = pred_take_i; m_id_dest[k] = pred_dest_i;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_ex(input logic br, input logic tk, input logic [31:0] tgt);
    ex_is_branch_i = br; ex_taken_i = tk; ex_target_i = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; stall_i = 0; flush_i = 0; if_valid_i = 0; set_ex(0, 0, 0);
    tick(); tick();
    rst_n = 1'b0;
  endtask

  // Put one predicted instruction into the EX slot. Two clean cycles are needed.
  task automatic load_ex(input logic [31:0] pc, input logic tk, input logic [31:0] dst);
    set_ex(0, 0, 0);
    if_valid_i = 1; if_pc_i = pc; pred_take_i = tk; pred_dest_i = dst;
    tick();
    if_valid_i = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (d_fb !== 1'b0) begin n_bad++; $display("FAIL rst_fb got %0h want 0", d_fb); end
    n_vec++; if (d_spc !== 32'd0) begin n_bad++; $display("FAIL rst_set_pc got %h want 0", d_spc); end
    n_vec++; if (d_stk !== 1'b0) begin n_bad++; $display("FAIL rst_set_taken got %0h want 0", d_stk); end
    n_vec++; if (d_sdst !== 32'd0) begin n_bad++; $display("FAIL rst_set_dest got %h want 0", d_sdst); end
    n_vec++; if (d_bc !== 32'd0 || d_mc !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got %0d/%0d want 0/0", d_bc, d_mc); end
    set_ex(1, 1, 32'h44); #1;
    n_vec++; if (d_mis !== 1'b0 || d_red !== 32'd0) begin n_bad++; $display("FAIL rst_redirect got %0h/%h want 0/0", d_mis, d_red); end
    set_ex(0, 0, 0);
  endtask

  task automatic test_correct();
    do_reset();
    load_ex(32'h100, 1, 32'h200);
    set_ex(1, 1, 32'h200); #1;
    n_vec++; if (d_mis !== 1'b0) begin n_bad++; $display("FAIL corr_mis got %0h want 0", d_mis); end
    tick(); set_ex(0, 0, 0);
    n_vec++; if (d_fb !== 1'b1) begin n_bad++; $display("FAIL corr_fb got %0h want 1", d_fb); end
    n_vec++; if (d_spc !== 32'h100) begin n_bad++; $display("FAIL corr_set_pc got %h want 100", d_spc); end
    n_vec++; if (d_stk !== 1'b1) begin n_bad++; $display("FAIL corr_set_taken got %0h want 1", d_stk); end
    n_vec++; if (d_sdst !== 32'h200) begin n_bad++; $display("FAIL corr_set_dest got %h want 200", d_sdst); end
    n_vec++; if (d_bc !== 32'd1 || d_mc !== 32'd0) begin n_bad++; $display("FAIL corr_cnt got %0d/%0d want 1/0", d_bc, d_mc); end
    tick();
    n_vec++; if (d_fb !== 1'b0 || d_spc !== 32'h100) begin n_bad++; $display("FAIL corr_pulse got %0h/%h want 0/100", d_fb, d_spc); end
  endtask

  task automatic test_dir_mispredict();
    do_reset();
    if_valid_i = 1; if_pc_i = 32'h40; pred_take_i = 0; pred_dest_i = 0; tick();
    if_pc_i = 32'h50; pred_take_i = 0; tick();
    if_pc_i = 32'h60;
    set_ex(1, 1, 32'h80); #1;
    n_vec++; if (d_mis !== 1'b1) begin n_bad++; $display("FAIL dir_mis got %0h want 1", d_mis); end
    n_vec++; if (d_red !== 32'h80) begin n_bad++; $display("FAIL dir_redirect got %h want 80", d_red); end
    tick();
    if_valid_i = 0; set_ex(1, 0, 32'h0);
    n_vec++; if (d_mc !== 32'd1 || d_bc !== 32'd1) begin n_bad++; $display("FAIL dir_cnt got %0d/%0d want 1/1", d_bc, d_mc); end
    n_vec++; if (d_fb !== 1'b1 || d_sdst !== 32'h80) begin n_bad++; $display("FAIL dir_fb got %0h/%h want 1/80", d_fb, d_sdst); end
    #1;
    n_vec++; if (d_mis !== 1'b0) begin n_bad++; $display("FAIL dir_killed_mis got %0h want 0", d_mis); end
    tick();
    n_vec++; if (d_fb !== 1'b0) begin n_bad++; $display("FAIL dir_killed_fb got %0h want 0", d_fb); end
    tick();
    set_ex(0, 0, 0);
    n_vec++; if (d_fb !== 1'b0 || d_bc !== 32'd1) begin n_bad++; $display("FAIL dir_ignored_if got %0h/%0d want 0/1", d_fb, d_bc); end
  endtask

  task automatic test_fallthrough();
    do_reset();
    load_ex(32'hFFFF_FFFC, 1, 32'h1000);
    set_ex(1, 0, 32'h1234); #1;
    n_vec++; if (d_mis !== 1'b1 || d_red !== 32'h0) begin n_bad++; $display("FAIL wrap_redirect got %0h/%h want 1/0", d_mis, d_red); end
    n_vec++; if (n_mis !== 1'b1) begin n_bad++; $display("FAIL wrap_mis_nt got %0h want 1", n_mis); end
    tick();
    load_ex(32'h7C, 1, 32'h1000);
    set_ex(1, 0, 32'h0); #1;
    n_vec++; if (d_red !== 32'h80) begin n_bad++; $display("FAIL fall_redirect got %h want 80", d_red); end
    tick(); set_ex(0, 0, 0);
  endtask

  task automatic test_target();
    do_reset();
    load_ex(32'h10, 1, 32'h300);
    set_ex(1, 1, 32'h304); #1;
    n_vec++; if (d_mis !== 1'b1 || d_red !== 32'h304) begin n_bad++; $display("FAIL tgt_mis got %0h/%h want 1/304", d_mis, d_red); end
    n_vec++; if (n_mis !== 1'b0 || n_red !== 32'h0) begin n_bad++; $display("FAIL tgt_dironly got %0h/%h want 0/0", n_mis, n_red); end
    tick();
    n_vec++; if (d_mc !== 32'd1 || n_mc !== 3'd0 || n_bc !== 3'd1) begin n_bad++; $display("FAIL tgt_cnt got %0d/%0d/%0d want 1/0/1", d_mc, n_mc, n_bc); end
    load_ex(32'h20, 1, 32'h300);
    set_ex(1, 1, 32'h301); #1;
    n_vec++; if (d_mis !== 1'b0) begin n_bad++; $display("FAIL tgt_bit0_mis got %0h want 0", d_mis); end
    tick(); set_ex(0, 0, 0);
    n_vec++; if (d_sdst !== 32'h300 || d_spc !== 32'h20) begin n_bad++; $display("FAIL tgt_bit0_fb got %h/%h want 300/20", d_sdst, d_spc); end
  endtask

  task automatic test_stall();
    do_reset();
    load_ex(32'h700, 1, 32'h740);
    set_ex(1, 0, 32'h0);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (d_mis !== 1'b0) begin n_bad++; $display("FAIL stall_mis[%0d] got %0h want 0", i, d_mis); end
      tick();
      n_vec++; if (d_fb !== 1'b0 || d_bc !== 32'd0) begin n_bad++; $display("FAIL stall_hold[%0d] got %0h/%0d want 0/0", i, d_fb, d_bc); end
    end
    stall_i = 0; #1;
    n_vec++; if (d_mis !== 1'b1 || d_red !== 32'h704) begin n_bad++; $display("FAIL stall_release got %0h/%h want 1/704", d_mis, d_red); end
    tick();
    n_vec++; if (d_fb !== 1'b1 || d_bc !== 32'd1 || d_mc !== 32'd1) begin n_bad++; $display("FAIL stall_once got %0h/%0d/%0d want 1/1/1", d_fb, d_bc, d_mc); end
    tick(); set_ex(0, 0, 0);
    n_vec++; if (d_fb !== 1'b0 || d_bc !== 32'd1) begin n_bad++; $display("FAIL stall_single got %0h/%0d want 0/1", d_fb, d_bc); end
  endtask

  task automatic test_flush();
    do_reset();
    if_valid_i = 1; if_pc_i = 32'hA0; pred_take_i = 0; pred_dest_i = 0; tick();
    if_pc_i = 32'hB0; flush_i = 1; tick();
    flush_i = 0; if_valid_i = 0;
    set_ex(1, 0, 32'h0); tick();
    n_vec++; if (d_fb !== 1'b1 || d_spc !== 32'hA0) begin n_bad++; $display("FAIL flush_ex_adv got %0h/%h want 1/a0", d_fb, d_spc); end
    tick();
    n_vec++; if (d_fb !== 1'b0 || d_bc !== 32'd1) begin n_bad++; $display("FAIL flush_id_kill got %0h/%0d want 0/1", d_fb, d_bc); end
    set_ex(0, 0, 0);
    if_valid_i = 1; if_pc_i = 32'hC0; tick();
    if_valid_i = 0; stall_i = 1; flush_i = 1; tick();
    stall_i = 0; flush_i = 0; tick();
    set_ex(1, 0, 32'h0); tick(); set_ex(0, 0, 0);
    n_vec++; if (d_fb !== 1'b0 || d_bc !== 32'd1) begin n_bad++; $display("FAIL flush_stall got %0h/%0d want 0/1", d_fb, d_bc); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    load_ex(32'h100, 1, 32'h200); set_ex(1, 1, 32'h200); tick();
    load_ex(32'h500, 0, 32'h0);
    set_ex(1, 1, 32'h600);
    rst_n = 1; tick(); rst_n = 0;
    n_vec++; if (d_fb !== 1'b0 || d_spc !== 32'd0 || d_sdst !== 32'd0 || d_stk !== 1'b0) begin n_bad++; $display("FAIL midrst_fb got %0h/%h/%h/%0h want 0/0/0/0", d_fb, d_spc, d_sdst, d_stk); end
    n_vec++; if (d_bc !== 32'd0 || d_mc !== 32'd0) begin n_bad++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", d_bc, d_mc); end
    #1;
    n_vec++; if (d_mis !== 1'b0 || d_red !== 32'd0) begin n_bad++; $display("FAIL midrst_redirect got %0h/%h want 0/0", d_mis, d_red); end
    tick(); tick(); set_ex(0, 0, 0);
    n_vec++; if (d_fb !== 1'b0 || d_bc !== 32'd0) begin n_bad++; $display("FAIL midrst_later got %0h/%0d want 0/0", d_fb, d_bc); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      load_ex(32'h900 + 32'(i * 16), 0, 32'h0);
      set_ex(1, 1, 32'hA00); tick();
      if (i == 6) begin
        n_vec++; if (n_mc !== 3'd7) begin n_bad++; $display("FAIL sat_reach got %0d want 7", n_mc); end
      end
    end
    set_ex(0, 0, 0);
    n_vec++; if (n_mc !== 3'd7 || n_bc !== 3'd7) begin n_bad++; $display("FAIL sat_hold got %0d/%0d want 7/7", n_bc, n_mc); end
    n_vec++; if (d_mc !== 32'd9) begin n_bad++; $display("FAIL sat_wide got %0d want 9", d_mc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n          = ($urandom_range(0, 59) == 0);
      stall_i        = ($urandom_range(0, 4) == 0);
      flush_i        = ($urandom_range(0, 9) == 0);
      if_valid_i     = ($urandom_range(0, 3) != 0);
      if_pc_i        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'(4 * $urandom_range(0, 63));
      pred_take_i    = 1'($urandom);
      pred_dest_i    = 32'(4 * $urandom_range(0, 3));
      ex_is_branch_i = ($urandom_range(0, 9) < 7);
      ex_taken_i     = 1'($urandom);
      ex_target_i    = 32'(4 * $urandom_range(0, 3)) | 32'($urandom_range(0, 1));
      #1; model_comb();
      n_vec++; if (d_mis !== e_mis[0] || d_red !== e_red[0]) begin n_bad++; $display("FAIL rnd_redirect c%0d got %0h/%h want %0h/%h", c, d_mis, d_red, e_mis[0], e_red[0]); end
      n_vec++; if (n_mis !== e_mis[1] || n_red !== e_red[1]) begin n_bad++; $display("FAIL rnd_redirect_nt c%0d got %0h/%h want %0h/%h", c, n_mis, n_red, e_mis[1], e_red[1]); end
      tick();
      n_vec++; if (d_fb !== m_fb[0] || d_spc !== m_spc[0] || d_stk !== m_stk[0] || d_sdst !== m_sdst[0]) begin n_bad++; $display("FAIL rnd_fb c%0d got %0h/%h/%0h/%h want %0h/%h/%0h/%h", c, d_fb, d_spc, d_stk, d_sdst, m_fb[0], m_spc[0], m_stk[0], m_sdst[0]); end
      n_vec++; if (n_fb !== m_fb[1] || n_spc !== m_spc[1] || n_stk !== m_stk[1] || n_sdst !== m_sdst[1]) begin n_bad++; $display("FAIL rnd_fb_nt c%0d got %0h/%h/%0h/%h want %0h/%h/%0h/%h", c, n_fb, n_spc, n_stk, n_sdst, m_fb[1], m_spc[1], m_stk[1], m_sdst[1]); end
      n_vec++; if (d_bc !== m_bc[0] || d_mc !== m_mc[0]) begin n_bad++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, d_bc, d_mc, m_bc[0], m_mc[0]); end
      n_vec++; if ({29'd0, n_bc} !== m_bc[1] || {29'd0, n_mc} !== m_mc[1]) begin n_bad++; $display("FAIL rnd_cnt_nt c%0d got %0d/%0d want %0d/%0d", c, n_bc, n_mc, m_bc[1], m_mc[1]); end
    end
    rst_n = 0; stall_i = 0; flush_i = 0; if_valid_i = 0; set_ex(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_fallthrough();
    test_target();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
